// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FREEZE   = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [1:0] PCSRC_SEQ  = 2'd0;
  localparam logic [1:0] PCSRC_BR   = 2'd1;
  localparam logic [1:0] PCSRC_JMP  = 2'd2;
  localparam logic [1:0] PCSRC_HOLD = 2'd3;

  localparam int DEF_PC_W        = 32;
  localparam int DEF_REG_W       = 5;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/pc_hazard_controller_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_hazard_controller.sv
// PC / pipeline-register sequencing: memory freeze, taken branch, load-use
// stall and jump, resolved in that priority order.
module pc_hazard_controller
  import hazard_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] IDRs,
  input  logic [REG_W-1:0] IDRt,
  input  logic             IDUsesRt,
  input  logic             IDJump,
  input  logic [PC_W-1:0]  IDJumpTarget,
  input  logic             EXMemRead,
  input  logic [REG_W-1:0] EXRd,
  input  logic             EXBranchTaken,
  input  logic [PC_W-1:0]  EXBranchTarget,
  input  logic [PC_W-1:0]  PCPlus4,
  input  logic             MEMAccess,
  input  logic             DMemReady,
  output logic [PC_W-1:0]  PCNext,
  output logic             PCStall,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             PipeFreeze,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic             MemTimeout,
  output logic [1:0]       DbgState
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(MEM_TIMEOUT);

  state_t          state, state_next;
  logic            id_valid;
  logic [TW-1:0]   freeze_timer;
  logic [1:0]      pc_src;

  logic freeze_c, in_redirect, load_use_c;
  logic do_freeze, do_branch, do_load_use, do_jump;

  // Event decode; load-use and jump are blind while ID holds a redirect bubble.
  assign freeze_c    = MEMAccess && !DMemReady;
  assign in_redirect = (state == REDIRECT);
  assign load_use_c  = !in_redirect && id_valid && EXMemRead && (EXRd != '0) &&
                       ((EXRd == IDRs) || (IDUsesRt && (EXRd == IDRt)));

  assign do_freeze   = freeze_c;
  assign do_branch   = !freeze_c && EXBranchTaken;
  assign do_load_use = !freeze_c && !EXBranchTaken && load_use_c;
  assign do_jump     = !freeze_c && !EXBranchTaken && !load_use_c &&
                       !in_redirect && id_valid && IDJump;

  assign DbgState = state;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = RUN;
    if (do_freeze) begin
      state_next = FREEZE;
    end else if (do_branch || do_jump) begin
      state_next = REDIRECT;
    end
  end

  always_comb begin
    pc_src     = PCSRC_SEQ;
    PCStall    = 1'b0;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    PipeFreeze = 1'b0;
    if (Reset) begin
      if (do_freeze) begin
        PipeFreeze = 1'b1;
        PCStall    = 1'b1;
        IFIDWrite  = 1'b0;
        pc_src     = PCSRC_HOLD;
      end else if (do_branch) begin
        pc_src    = PCSRC_BR;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
      end else if (do_load_use) begin
        PCStall   = 1'b1;
        IFIDWrite = 1'b0;
        IDEXFlush = 1'b1;
        pc_src    = PCSRC_HOLD;
      end else if (do_jump) begin
        pc_src    = PCSRC_JMP;
        IFIDFlush = 1'b1;
      end
    end
  end

  // HOLD still presents PCPlus4; PCStall keeps the PC from taking it.
  always_comb begin
    PCNext = PCPlus4;
    case (pc_src)
      PCSRC_BR:  PCNext = EXBranchTarget;
      PCSRC_JMP: PCNext = IDJumpTarget;
      default:   PCNext = PCPlus4;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      id_valid <= 1'b0;
    end else if (IFIDFlush) begin
      id_valid <= 1'b0;
    end else if (IFIDWrite) begin
      id_valid <= 1'b1;
    end
  end

  // Timeout only reports; the freeze is never broken by the controller.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      freeze_timer <= '0;
      MemTimeout   <= 1'b0;
    end else if (do_freeze) begin
      if (freeze_timer != TIMER_MAX) begin
        freeze_timer <= freeze_timer + 1'b1;
      end
      if (freeze_timer >= (TIMER_MAX - 1'b1)) begin
        MemTimeout <= 1'b1;
      end
    end else begin
      freeze_timer <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .inc   (do_freeze || do_load_use),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .inc   (do_branch || do_jump),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_pc_hazard_controller.sv
// Directed bench for pc_hazard_controller with a short timeout and 3-bit counters.
module tb_pc_hazard_controller;
  import hazard_pkg::*;

  localparam int PC_W  = 32;
  localparam int REG_W = 5;
  localparam int CNT_W = 3;

  logic             Clk;
  logic             Reset;
  logic [REG_W-1:0] IDRs, IDRt, EXRd;
  logic             IDUsesRt, IDJump, EXMemRead, EXBranchTaken, MEMAccess, DMemReady;
  logic [PC_W-1:0]  IDJumpTarget, EXBranchTarget, PCPlus4, PCNext;
  logic             PCStall, IFIDWrite, IFIDFlush, IDEXFlush, PipeFreeze, MemTimeout;
  logic [CNT_W-1:0] StallCount, FlushCount;
  logic [1:0]       DbgState;

  int checks = 0;
  int errors = 0;

  pc_hazard_controller #(
    .PC_W(PC_W), .REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(4)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
    .IDJump(IDJump), .IDJumpTarget(IDJumpTarget),
    .EXMemRead(EXMemRead), .EXRd(EXRd),
    .EXBranchTaken(EXBranchTaken), .EXBranchTarget(EXBranchTarget),
    .PCPlus4(PCPlus4), .MEMAccess(MEMAccess), .DMemReady(DMemReady),
    .PCNext(PCNext), .PCStall(PCStall), .IFIDWrite(IFIDWrite),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .PipeFreeze(PipeFreeze),
    .StallCount(StallCount), .FlushCount(FlushCount),
    .MemTimeout(MemTimeout), .DbgState(DbgState)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    IDRs = '0; IDRt = '0; IDUsesRt = 1'b0; IDJump = 1'b0; IDJumpTarget = '0;
    EXMemRead = 1'b0; EXRd = '0; EXBranchTaken = 1'b0; EXBranchTarget = '0;
    MEMAccess = 1'b0; DMemReady = 1'b0;
  endtask

  task automatic reset_pulse();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    PCPlus4 = 32'h20;
    Reset   = 1'b0;
    settle();
    check("rst_pcnext", PCNext, 32'h20);
    check("rst_pcstall", PCStall, 0);
    check("rst_ifidwrite", IFIDWrite, 1);
    check("rst_flushes", {IFIDFlush, IDEXFlush}, 0);
    check("rst_freeze", PipeFreeze, 0);
    check("rst_counts", {StallCount, FlushCount}, 0);
    check("rst_timeout", MemTimeout, 0);
    check("rst_state", DbgState, RUN);
    tick();
    Reset = 1'b1;
    tick();

    // Freeze for 10 cycles, then reset in the middle of it
    MEMAccess = 1'b1; DMemReady = 1'b0;
    settle();
    check("frz_pipefreeze", PipeFreeze, 1);
    check("frz_pcstall", PCStall, 1);
    check("frz_ifidwrite", IFIDWrite, 0);
    repeat (10) tick();
    check("frz_state", DbgState, FREEZE);
    check("frz_stall_sat", StallCount, 7);
    check("frz_timeout", MemTimeout, 1);
    Reset = 1'b0;
    settle();
    check("midrst_pipefreeze", PipeFreeze, 0);
    check("midrst_pcstall", PCStall, 0);
    check("midrst_ifidwrite", IFIDWrite, 1);
    check("midrst_stall", StallCount, 0);
    check("midrst_timeout", MemTimeout, 0);
    MEMAccess = 1'b0;
    tick();
    Reset = 1'b1;
    tick();

    // Load-use on Rs
    EXMemRead = 1'b1; EXRd = 5'd8; IDRs = 5'd8;
    settle();
    check("lu_pcstall", PCStall, 1);
    check("lu_ifidwrite", IFIDWrite, 0);
    check("lu_idexflush", IDEXFlush, 1);
    check("lu_ififlush", IFIDFlush, 0);
    check("lu_stall_before", StallCount, 0);
    tick();
    EXMemRead = 1'b0;
    settle();
    check("lu_stall_after", StallCount, 1);
    check("lu_no_repeat", PCStall, 0);

    // Rt match only counts when IDUsesRt
    EXMemRead = 1'b1; EXRd = 5'd9; IDRs = 5'd3; IDRt = 5'd9; IDUsesRt = 1'b0;
    settle();
    check("lu_rt_unused", PCStall, 0);
    tick();
    IDUsesRt = 1'b1;
    settle();
    check("lu_rt_used", PCStall, 1);
    tick();
    check("lu_rt_count", StallCount, 2);

    // Register 0 never hazards
    EXRd = 5'd0; IDRs = 5'd0; IDRt = 5'd0;
    settle();
    check("lu_r0_stall", PCStall, 0);
    check("lu_r0_flush", IDEXFlush, 0);
    tick();

    // Taken branch alongside a load-use match
    EXMemRead = 1'b1; EXRd = 5'd8; IDRs = 5'd8; IDUsesRt = 1'b0;
    EXBranchTaken = 1'b1; EXBranchTarget = 32'h40;
    settle();
    check("br_pcnext", PCNext, 32'h40);
    check("br_ifidflush", IFIDFlush, 1);
    check("br_idexflush", IDEXFlush, 1);
    check("br_pcstall", PCStall, 0);
    tick();
    check("br_stall_unch", StallCount, 2);
    check("br_flush_cnt", FlushCount, 1);
    check("br_state", DbgState, REDIRECT);
    EXBranchTaken = 1'b0; IDJump = 1'b1; IDJumpTarget = 32'h100;
    settle();
    check("redir_lu_ignored", PCStall, 0);
    check("redir_jmp_ignored", IFIDFlush, 0);
    check("redir_pcnext", PCNext, 32'h20);
    tick();
    check("redir_back_run", DbgState, RUN);

    // Jump
    EXMemRead = 1'b0;
    settle();
    check("jmp_pcnext", PCNext, 32'h100);
    check("jmp_ifidflush", IFIDFlush, 1);
    check("jmp_idexflush", IDEXFlush, 0);
    check("jmp_pcstall", PCStall, 0);
    tick();
    check("jmp_flush_cnt", FlushCount, 2);
    check("jmp_state", DbgState, REDIRECT);
    settle();
    check("jmp_bubble_pcnext", PCNext, 32'h20);
    IDJump = 1'b0;
    tick();

    // Freeze beats branch; branch taken once memory is ready
    MEMAccess = 1'b1; DMemReady = 1'b0; EXBranchTaken = 1'b1; EXBranchTarget = 32'h40;
    settle();
    check("frzbr_freeze", PipeFreeze, 1);
    check("frzbr_noflush", IFIDFlush, 0);
    check("frzbr_pcnext", PCNext, 32'h20);
    tick();
    check("frzbr_flush_cnt", FlushCount, 2);
    check("frzbr_stall_cnt", StallCount, 3);
    DMemReady = 1'b1;
    settle();
    check("frzbr_release_pc", PCNext, 32'h40);
    check("frzbr_release_fl", IFIDFlush, 1);
    check("frzbr_release_fz", PipeFreeze, 0);
    tick();
    check("frzbr_flush_after", FlushCount, 3);
    idle_inputs();

    // Timeout after the 4th freeze cycle, sticky afterwards
    reset_pulse();
    MEMAccess = 1'b1; DMemReady = 1'b0;
    repeat (3) tick();
    check("to_before", MemTimeout, 0);
    tick();
    check("to_at4", MemTimeout, 1);
    repeat (2) tick();
    check("to_stall6", StallCount, 6);
    check("to_held", MemTimeout, 1);
    DMemReady = 1'b1;
    settle();
    check("to_release", PipeFreeze, 0);
    tick();
    check("to_sticky", MemTimeout, 1);
    check("to_stall_final", StallCount, 6);
    check("to_state", DbgState, RUN);
    idle_inputs();

    // Counter saturation over 9 load-use stalls
    reset_pulse();
    EXMemRead = 1'b1; EXRd = 5'd8; IDRs = 5'd8;
    repeat (6) tick();
    check("sat_six", StallCount, 6);
    repeat (3) tick();
    check("sat_seven", StallCount, 7);
    check("sat_still_stall", PCStall, 1);
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
